// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: fetch-unit bus bundle.
// Carries the control inputs (redirect_valid, redirect_pc, halt, id_ready),
// the memory port (mem_req, mem_addr, mem_gnt, mem_rvalid, mem_rdata) and
// the instruction-queue head toward IF/ID (if_valid, if_pc, if_pc4, if_inst).
// master = fetch unit, slave = surrounding pipeline/memory.
interface if_fetch_unit_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        id_ready;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   logic [31:0] if_inst;
   modport master (
      input  redirect_valid, redirect_pc, halt, id_ready, mem_gnt, mem_rvalid, mem_rdata,
      output mem_req, mem_addr, if_valid, if_pc, if_pc4, if_inst
   );
   modport slave (
      output redirect_valid, redirect_pc, halt, id_ready, mem_gnt, mem_rvalid, mem_rdata,
      input  mem_req, mem_addr, if_valid, if_pc, if_pc4, if_inst
   );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with one outstanding request and a 2-entry queue.
// Ports: clk, reset (sync, active-high) and bus (if_fetch_unit_if.master) carrying
// redirect/halt/id_ready controls, the memory request/response port and the
// queue head (if_valid/if_pc/if_pc4/if_inst) toward IF/ID.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input logic           clk,
   input logic           reset,
   if_fetch_unit_if.master bus
);
   typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
   logic        drop_q, drop_d;
   logic [1:0]  count_q, count_d;
   logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [31:0] qpc_q [QDEPTH];
   logic [31:0] qinst_q [QDEPTH];
   logic        resp, issue, push, pop;
   // Only IDLE can issue, so nothing is outstanding and count < QDEPTH keeps a slot free for the reply.
   assign bus.mem_req  = !reset && state_q == IDLE && !bus.halt && !bus.redirect_valid && int'(count_q) < QDEPTH;
   assign bus.mem_addr = pc_q;
   assign bus.if_valid = !reset && count_q != 2'd0;
   assign bus.if_pc    = bus.if_valid ? qpc_q[rd_ptr_q] : 32'h0;
   assign bus.if_pc4   = bus.if_valid ? qpc_q[rd_ptr_q] + 32'd4 : 32'h0;
   assign bus.if_inst  = bus.if_valid ? qinst_q[rd_ptr_q] : 32'h0;
   assign resp  = state_q == WAIT && bus.mem_rvalid;
   assign issue = bus.mem_req && bus.mem_gnt;
   assign push  = resp && !drop_q && !bus.redirect_valid;
   assign pop   = bus.if_valid && bus.id_ready && !bus.redirect_valid;
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      drop_d   = drop_q;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      if (issue) begin
         pc_d     = pc_q + 32'd4;
         req_pc_d = pc_q;
         state_d  = WAIT;
      end else if (state_q == IDLE && bus.halt)
         state_d = HALTED;
      else if (state_q == HALTED && !bus.halt)
         state_d = IDLE;
      else if (resp) begin
         state_d = bus.halt ? HALTED : IDLE;
         drop_d  = 1'b0;
      end else if (state_q == WAIT && bus.redirect_valid)
         drop_d = 1'b1;
      // A reply landing in the redirect cycle is discarded right here, so drop is only armed when it is still pending.
      if (bus.redirect_valid) begin
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         pc_d     = bus.redirect_pc & ~32'h3;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         drop_q   <= 1'b0;
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         drop_q   <= drop_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         qpc_q[wr_ptr_q]   <= req_pc_q;
         qinst_q[wr_ptr_q] <= bus.mem_rdata;
      end
   end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed table plus hand sequences for if_fetch_unit.
module tb_if_fetch_unit;
   logic clk = 1'b0;
   logic reset;
   if_fetch_unit_if bus();
   if_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus.master));
   always #5 clk = ~clk;
   typedef struct packed {
      logic        rdy;
      logic        gnt;
      logic        halt;
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] pc;
   } vec_t;
   vec_t tbl [24];
   int tests = 0;
   int fails = 0;
   int lat = 1;
   bit pend = 0;
   int pend_cnt = 0;
   logic [31:0] pend_addr = 0;
   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction
   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %h exp %h", n, got, exp);
      end
   endtask
   task automatic expect_out(input string t, input logic req, input logic [31:0] addr, input logic v, input logic [31:0] pc);
      logic [31:0] p4;
      p4 = pc + 32'd4;
      chk({t, ".mem_req"}, {31'b0, bus.mem_req}, {31'b0, req});
      if (req) chk({t, ".mem_addr"}, bus.mem_addr, addr);
      chk({t, ".if_valid"}, {31'b0, bus.if_valid}, {31'b0, v});
      chk({t, ".if_pc"}, bus.if_pc, v ? pc : 32'h0);
      chk({t, ".if_pc4"}, bus.if_pc4, v ? p4 : 32'h0);
      chk({t, ".if_inst"}, bus.if_inst, v ? inst_of(pc) : 32'h0);
   endtask
   task automatic settle();
      @(negedge clk);
   endtask
   // Advance one edge and model memory: reply lat cycles after a grant.
   task automatic adv();
      logic g;
      logic [31:0] ga;
      g  = bus.mem_req & bus.mem_gnt;
      ga = bus.mem_addr;
      @(posedge clk);
      #1;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
      if (g) begin
         pend = 1;
         pend_addr = ga;
         pend_cnt = lat;
      end
      if (pend) begin
         if (pend_cnt <= 1) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = inst_of(pend_addr);
            pend = 0;
         end else pend_cnt--;
      end
   endtask
   task automatic idle_inputs();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.halt           = 1'b0;
      bus.id_ready       = 1'b1;
      bus.mem_gnt        = 1'b1;
   endtask
   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         settle();
         chk("reset.mem_req", {31'b0, bus.mem_req}, 32'h0);
         chk("reset.if_valid", {31'b0, bus.if_valid}, 32'h0);
         adv();
      end
      reset = 1'b0;
   endtask
   initial begin
      tbl = '{
         '{1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00},
         '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00},
         '{1'b1, 1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00},
         '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00},
         '{1'b0, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h04},
         '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04},
         '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04},
         '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04},
         '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04},
         '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04},
         '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04},
         '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h08},
         '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00},
         '{1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0C},
         '{1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h00},
         '{1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h00},
         '{1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h00},
         '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00},
         '{1'b1, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h10},
         '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00},
         '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h14},
         '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00},
         '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00},
         '{1'b1, 1'b1, 1'b0, 1'b1, 32'h18, 1'b0, 32'h00}
      };
      idle_inputs();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      do_reset(2);
      for (int i = 0; i < 24; i++) begin
         bus.id_ready = tbl[i].rdy;
         bus.mem_gnt  = tbl[i].gnt;
         bus.halt     = tbl[i].halt;
         settle();
         expect_out($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].pc);
         adv();
      end
      // Redirect to 0x103 while a 3-cycle fetch is in flight.
      idle_inputs();
      pend = 0;
      lat = 3;
      do_reset(1);
      settle();
      expect_out("redir.c0", 1'b1, 32'h0, 1'b0, 32'h0);
      adv();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0103;
      settle();
      expect_out("redir.c1", 1'b0, 32'h0, 1'b0, 32'h0);
      adv();
      bus.redirect_valid = 1'b0;
      settle();
      expect_out("redir.c2", 1'b0, 32'h0, 1'b0, 32'h0);
      adv();
      settle();
      chk("redir.stale_rvalid", {31'b0, bus.mem_rvalid}, 32'h1);
      expect_out("redir.c3", 1'b0, 32'h0, 1'b0, 32'h0);
      lat = 1;
      adv();
      settle();
      expect_out("redir.c4", 1'b1, 32'h100, 1'b0, 32'h0);
      adv();
      settle();
      expect_out("redir.c5", 1'b0, 32'h0, 1'b0, 32'h0);
      adv();
      settle();
      expect_out("redir.c6", 1'b1, 32'h104, 1'b1, 32'h100);
      adv();
      // PC wrap at 0xFFFF_FFFC.
      idle_inputs();
      pend = 0;
      do_reset(1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      settle();
      expect_out("wrap.c0", 1'b0, 32'h0, 1'b0, 32'h0);
      adv();
      bus.redirect_valid = 1'b0;
      settle();
      expect_out("wrap.c1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      adv();
      settle();
      expect_out("wrap.c2", 1'b0, 32'h0, 1'b0, 32'h0);
      adv();
      settle();
      expect_out("wrap.c3", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);
      adv();
      // Reset while a fetch is outstanding; its late reply must be ignored.
      idle_inputs();
      pend = 0;
      lat = 2;
      do_reset(1);
      settle();
      expect_out("rstfly.c0", 1'b1, 32'h0, 1'b0, 32'h0);
      adv();
      do_reset(1);
      bus.mem_gnt = 1'b0;
      settle();
      chk("rstfly.late_rvalid", {31'b0, bus.mem_rvalid}, 32'h1);
      expect_out("rstfly.c2", 1'b1, 32'h0, 1'b0, 32'h0);
      adv();
      settle();
      expect_out("rstfly.c3", 1'b1, 32'h0, 1'b0, 32'h0);
      adv();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
